sram_axi_bridge: RTL and testbench

//   Converts the two sram-like master ports leaving the cache wrapper (cache_inst_*,

---
 rtl/sram_axi_bridge.sv | 198 +++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the cache wrapper's inst/data sram-like ports onto one single-beat AXI3 master.
// Optional SRAM2AXI_WRESP_WAIT_EN: write data_ok waits for the B response instead of AW/W completion.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_AR  = 3'd1;
  localparam logic [2:0] S_RD_R   = 3'd2;
  localparam logic [2:0] S_WR_AWW = 3'd3;
  localparam logic [2:0] S_WR_B   = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic        owner_data_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        aw_done_reg;
  logic        w_done_reg;

  logic grant_data, grant_inst;
  logic aw_hs, w_hs, aw_fin, w_fin, r_hs, b_hs, wr_ok;

  // Grants are suppressed while reset is held so no request is acknowledged and then lost.
  assign grant_data = (state_reg == S_IDLE) && data_req && !rst;
  assign grant_inst = (state_reg == S_IDLE) && !data_req && inst_req && !rst;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_fin = aw_done_reg || aw_hs;
  assign w_fin  = w_done_reg || w_hs;
  assign r_hs   = (state_reg == S_RD_R) && rvalid && !rst;
  assign b_hs   = (state_reg == S_WR_B) && bvalid;

`ifdef SRAM2AXI_WRESP_WAIT_EN
  assign wr_ok = b_hs && !rst;
`else
  assign wr_ok = (state_reg == S_WR_AWW) && aw_fin && w_fin && !rst;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_data)
          state_next = data_wr ? S_WR_AWW : S_RD_AR;
        else if (grant_inst)
          state_next = S_RD_AR;
      end
      S_RD_AR:  if (arready) state_next = S_RD_R;
      S_RD_R:   if (rvalid) state_next = S_IDLE;
      S_WR_AWW: if (aw_fin && w_fin) state_next = S_WR_B;
      S_WR_B:   if (bvalid) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      owner_data_reg <= 1'b0;
      wr_reg         <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_data) begin
        owner_data_reg <= 1'b1;
        wr_reg         <= data_wr;
        size_reg       <= data_size;
        addr_reg       <= data_addr;
        wdata_reg      <= data_wdata;
        aw_done_reg    <= 1'b0;
        w_done_reg     <= 1'b0;
      end else if (grant_inst) begin
        // The instruction port is read-only; its wr flag is ignored.
        owner_data_reg <= 1'b0;
        wr_reg         <= 1'b0;
        size_reg       <= inst_size;
        addr_reg       <= inst_addr;
        wdata_reg      <= 32'd0;
        aw_done_reg    <= 1'b0;
        w_done_reg     <= 1'b0;
      end else if (state_reg == S_WR_AWW) begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = r_hs && !owner_data_reg;
  assign data_data_ok = (r_hs && owner_data_reg) || wr_ok;
  assign inst_rdata   = (r_hs && !owner_data_reg) ? rdata : 32'd0;
  assign data_rdata   = (r_hs && owner_data_reg) ? rdata : 32'd0;

  assign arid    = owner_data_reg ? DATA_ID : INST_ID;
  assign araddr  = addr_reg;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_reg};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_reg == S_RD_AR);
  assign rready  = (state_reg == S_RD_R);

  assign awid    = DATA_ID;
  assign awaddr  = addr_reg;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_reg};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state_reg == S_WR_AWW) && !aw_done_reg;

  assign wid    = DATA_ID;
  assign wdata  = wdata_reg;
  assign wlast  = 1'b1;
  assign wvalid = (state_reg == S_WR_AWW) && !w_done_reg;
  assign bready = (state_reg == S_WR_B);

  // Write data stays unshifted; lane selection is carried entirely by the strobe.
  always_comb begin
    wstrb = 4'b1111;
    case (size_reg)
      2'd0:    wstrb = 4'b0001 << addr_reg[1:0];
      2'd1:    wstrb = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp, wr_reg};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle.
module tb_sram_axi_bridge;

`ifdef SRAM2AXI_WRESP_WAIT_EN
  localparam logic WR_LATE = 1'b1;
`else
  localparam logic WR_LATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0] arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
  endtask

  // Single read with the slave answering AR and R the cycle each valid appears.
  task automatic do_read(input logic is_data, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] rd);
    if (is_data) begin
      data_req = 1; data_wr = 0; data_addr = addr; data_size = size;
    end else begin
      inst_req = 1; inst_addr = addr; inst_size = size;
    end
    #1;
    chk("rd_addr_ok", is_data ? data_addr_ok : inst_addr_ok, 1);
    tick();
    data_req = 0; inst_req = 0;
    #1;
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, addr);
    chk("rd_arid", arid, is_data ? 32'd1 : 32'd0);
    chk("rd_arsize", arsize, {1'b0, size});
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = rd;
    #1;
    chk("rd_rready", rready, 1);
    chk("rd_own_ok", is_data ? data_data_ok : inst_data_ok, 1);
    chk("rd_other_ok", is_data ? inst_data_ok : data_data_ok, 0);
    chk("rd_rdata", is_data ? data_rdata : inst_rdata, rd);
    tick();
    rvalid = 0;
    #1;
    idle_checks("rd_end");
    $display("read  %s addr=%h data=%h", is_data ? "data" : "inst", addr, rd);
  endtask

  // Single write with AW and W accepted in the same cycle.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [3:0] strb);
    data_req = 1; data_wr = 1; data_addr = addr; data_size = size; data_wdata = wd;
    #1;
    chk("wr_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 0; data_wr = 0;
    #1;
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, addr);
    chk("wr_awsize", awsize, {1'b0, size});
    chk("wr_wstrb", wstrb, strb);
    chk("wr_wdata", wdata, wd);
    chk("wr_wlast", wlast, 1);
    chk("wr_ids", {awid, wid}, 8'h11);
    awready = 1; wready = 1;
    #1;
    chk("wr_ok_hs", data_data_ok, !WR_LATE);
    tick();
    awready = 0; wready = 0; bvalid = 1;
    #1;
    chk("wr_b_awvalid", awvalid, 0);
    chk("wr_b_wvalid", wvalid, 0);
    chk("wr_bready", bready, 1);
    chk("wr_ok_b", data_data_ok, WR_LATE);
    tick();
    bvalid = 0;
    #1;
    idle_checks("wr_end");
    $display("write data addr=%h size=%0d wdata=%h strb=%b", addr, size, wd, strb);
  endtask

  initial begin
    rst = 1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) tick();
    rst = 0;
    #1;
    idle_checks("reset");
    chk("reset_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk("reset_rdata", inst_rdata | data_rdata, 0);
    chk("consts", {arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot},
        {4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});

    // 1: instruction fetch at the reset vector
    do_read(1'b0, 32'hBFC0_0000, 2'd2, 32'h3C08_BFAF);

    // 2: simultaneous requests, data port wins
    tick();
    inst_req = 1; inst_addr = 32'hBFC0_0004; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0010; data_size = 2;
    #1;
    chk("arb_data_ok", data_addr_ok, 1);
    chk("arb_inst_blocked", inst_addr_ok, 0);
    tick();
    data_req = 0;
    #1;
    chk("arb_arid", arid, 1);
    chk("arb_araddr", araddr, 32'h8000_0010);
    chk("arb_no_grant_busy", inst_addr_ok, 0);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h1111_2222;
    #1;
    chk("arb_d_dok", data_data_ok, 1);
    chk("arb_d_rdata", data_rdata, 32'h1111_2222);
    chk("arb_i_dok0", inst_data_ok, 0);
    chk("arb_i_aok0", inst_addr_ok, 0);
    tick();
    rvalid = 0;
    #1;
    chk("arb_i_aok", inst_addr_ok, 1);
    chk("arb_d_dok_once", data_data_ok, 0);
    tick();
    inst_req = 0;
    #1;
    chk("arb_i_arid", arid, 0);
    chk("arb_i_araddr", araddr, 32'hBFC0_0004);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h5555_6666;
    #1;
    chk("arb_i_dok", inst_data_ok, 1);
    chk("arb_i_rdata", inst_rdata, 32'h5555_6666);
    chk("arb_i_d_dok0", data_data_ok, 0);
    tick();
    rvalid = 0;
    #1;
    chk("arb_i_dok_once", inst_data_ok, 0);
    $display("arbitration data-then-inst done");

    // 3: byte write to the top lane
    do_write(32'h8000_0003, 2'd0, 32'hAA00_0000, 4'b1000);

    // 4: AW accepted three cycles before W
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0020; data_size = 2; data_wdata = 32'h1234_5678;
    tick();
    data_req = 0; data_wr = 0; awready = 1;
    #1;
    chk("split_aw0", awvalid, 1);
    chk("split_w0", wvalid, 1);
    chk("split_ok0", data_data_ok, 0);
    tick();
    awready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("split_aw_dropped", awvalid, 0);
      chk("split_w_held", wvalid, 1);
      tick();
    end
    wready = 1;
    #1;
    chk("split_w_last", wvalid, 1);
    chk("split_ok_w", data_data_ok, !WR_LATE);
    tick();
    wready = 0;
    #1;
    chk("split_b_wait", {awvalid, wvalid, bready, data_data_ok}, 4'b0010);
    tick();
    bvalid = 1;
    #1;
    chk("split_ok_b", data_data_ok, WR_LATE);
    tick();
    bvalid = 0;
    #1;
    idle_checks("split_end");
    $display("write split addr=%h", 32'h8000_0020);

    // 5: strobe patterns
    do_write(32'h8000_0002, 2'd1, 32'hBEEF_0000, 4'b1100);
    do_write(32'h8000_0000, 2'd1, 32'h0000_BEEF, 4'b0011);
    do_write(32'h8000_0004, 2'd2, 32'hCAFE_F00D, 4'b1111);
    do_write(32'h8000_0001, 2'd0, 32'h0000_5500, 4'b0010);

    // 6: reset while waiting for R
    data_req = 1; data_wr = 0; data_addr = 32'h8000_0040; data_size = 2;
    tick();
    data_req = 0; arready = 1;
    tick();
    arready = 0;
    #1;
    chk("rst_in_rd_r", rready, 1);
    rst = 1;
    #1;
    chk("rst_no_dok", data_data_ok, 0);
    tick();
    rst = 0;
    #1;
    idle_checks("rst_after");
    chk("rst_after_dok", {inst_data_ok, data_data_ok}, 0);
    do_read(1'b1, 32'h8000_0044, 2'd2, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
